// File: rtl/node_bit_collector_pkg.sv
// node_bit_collector_pkg: shared sizing defaults and FSM encodings for the landscape sampling stages
package node_bit_collector_pkg;
    localparam int BIT_CHIP_DEF = 6;
    localparam int NODE_DEF = 16;
    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_SHIFT = 2'd1;
    localparam logic [1:0] ST_HOLD = 2'd2;
endpackage

// File: rtl/node_bit_collector_if.sv
// node_bit_collector_if: control, serial bit and collected-array signals of the bit collector
interface node_bit_collector_if import node_bit_collector_pkg::*; #(
    parameter int BIT_CHIP = BIT_CHIP_DEF,
    parameter int NODE = NODE_DEF
);
    logic start;
    logic bit_valid;
    logic [NODE-1:0] bit_in;
    logic array_ready;
    logic [BIT_CHIP*NODE-1:0] array_out;
    logic array_valid;
    logic busy;
    logic overrun;
    modport master (
        output start, bit_valid, bit_in, array_ready,
        input array_out, array_valid, busy, overrun
    );
    modport slave (
        input start, bit_valid, bit_in, array_ready,
        output array_out, array_valid, busy, overrun
    );
endinterface

// File: rtl/node_bit_collector.sv
// node_bit_collector: gathers one LSB-first serial word per node into a packed array with a valid/ready hold
module node_bit_collector import node_bit_collector_pkg::*; #(
    parameter int BIT_CHIP = BIT_CHIP_DEF,
    parameter int NODE = NODE_DEF
) (
    input logic clk,
    input logic rst,
    node_bit_collector_if.slave bus
);
    localparam int CW = BIT_CHIP > 1 ? $clog2(BIT_CHIP) : 1;
    localparam logic [CW-1:0] LAST = CW'(BIT_CHIP - 1);
    logic [1:0] state, state_nxt;
    logic [CW-1:0] cnt, cnt_base, cnt_nxt;
    logic [BIT_CHIP*NODE-1:0] data, data_base, data_nxt;
    logic [BIT_CHIP-1:0] sel;
    logic valid, overrun, restart, shifting, take, last;
    // a start in HOLD only counts when it coincides with the consumer handshake
    always_comb begin
        restart = bus.start && (state != ST_HOLD || bus.array_ready);
        shifting = restart || state == ST_SHIFT;
        take = shifting && bus.bit_valid;
        cnt_base = restart ? '0 : cnt;
        data_base = restart ? '0 : data;
        last = take && cnt_base == LAST;
        sel = BIT_CHIP'(1) << cnt_base;
        cnt_nxt = take ? (last ? '0 : cnt_base + CW'(1)) : cnt_base;
        state_nxt = shifting ? (last ? ST_HOLD : ST_SHIFT) :
                    (state == ST_HOLD && !bus.array_ready) ? ST_HOLD : ST_IDLE;
    end
    for (genvar n = 0; n < NODE; n++) begin : g_node
        assign data_nxt[n*BIT_CHIP +: BIT_CHIP] = take ?
            (data_base[n*BIT_CHIP +: BIT_CHIP] & ~sel) | ({BIT_CHIP{bus.bit_in[n]}} & sel) :
            data_base[n*BIT_CHIP +: BIT_CHIP];
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_IDLE;
            cnt <= '0;
            data <= '0;
            valid <= 1'b0;
            overrun <= 1'b0;
        end else begin
            state <= state_nxt;
            cnt <= cnt_nxt;
            data <= data_nxt;
            valid <= state_nxt == ST_HOLD;
            overrun <= overrun | (bus.bit_valid && !shifting);
        end
    end
    assign bus.array_out = data;
    assign bus.array_valid = valid;
    assign bus.busy = state != ST_IDLE;
    assign bus.overrun = overrun;
endmodule

// File: tb/tb_node_bit_collector.sv
// tb_node_bit_collector: randomized scoreboard bench with a word-level reference model
module tb_node_bit_collector;
    import node_bit_collector_pkg::*;
    localparam int BC = BIT_CHIP_DEF;
    localparam int N = NODE_DEF;
    localparam int W = BC * N;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;
    node_bit_collector_if #(.BIT_CHIP(BC), .NODE(N)) bus();
    node_bit_collector #(.BIT_CHIP(BC), .NODE(N)) dut (.clk(clk), .rst(rst), .bus(bus));
    int tests = 0;
    int fails = 0;
    logic [W-1:0] exp_q[$];
    int phase = 0;
    int nbits = 0;
    logic [W-1:0] cur = '0;
    bit ovr = 1'b0;
    bit was_rst = 1'b0;
    int ncyc = 0;
    task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask
    // phase: 0 waiting for start, 1 collecting bits, 2 holding a finished word
    task automatic cyc(input logic s, input logic bv, input logic [N-1:0] b, input logic r, input logic rs);
        bit go;
        @(negedge clk);
        if (ncyc > 0) begin
            chk("busy", W'(bus.busy), W'(phase != 0));
            chk("overrun", W'(bus.overrun), W'(ovr));
            chk("array_valid", W'(bus.array_valid), W'(phase == 2));
            if (was_rst) chk("array_out_after_rst", bus.array_out, '0);
        end
        ncyc++;
        rst = rs;
        bus.start = s;
        bus.bit_valid = bv;
        bus.bit_in = b;
        bus.array_ready = r;
        was_rst = rs;
        if (rs) begin
            phase = 0;
            nbits = 0;
            ovr = 1'b0;
        end else begin
            go = s && (phase != 2 || r);
            if (phase == 2 && r) phase = 0;
            if (go) begin
                phase = 1;
                nbits = 0;
                cur = '0;
            end
            if (phase == 1 && bv) begin
                for (int a = 0; a < N; a++) cur[a*BC + nbits] = b[a];
                nbits++;
                if (nbits == BC) begin
                    phase = 2;
                    exp_q.push_back(cur);
                end
            end else if (bv) begin
                ovr = 1'b1;
            end
        end
    endtask
    task automatic bits(input int k, input int gap);
        for (int i = 0; i < k; i++) begin
            cyc(0, 1, N'($urandom), 0, 0);
            for (int j = 0; j < gap; j++) cyc(0, 0, N'($urandom), 0, 0);
        end
    endtask
    initial begin
        logic prev;
        logic [W-1:0] held;
        prev = 1'b0;
        held = '0;
        forever begin
            @(negedge clk);
            if (bus.array_valid === 1'b1) begin
                if (!prev) begin
                    if (exp_q.size() == 0) begin
                        tests++;
                        fails++;
                        $display("FAIL unexpected_word: got %h expected no word", bus.array_out);
                    end else begin
                        chk("array_out", bus.array_out, exp_q.pop_front());
                    end
                    held = bus.array_out;
                end else begin
                    chk("array_out_stable", bus.array_out, held);
                end
            end
            prev = bus.array_valid === 1'b1;
        end
    end
    initial begin
        logic [N-1:0] pat [6];
        logic [BC-1:0] one;
        pat = '{1, 0, 1, 1, 0, 0};
        one = BC'(1);
        cyc(0, 0, '0, 0, 1);
        cyc(0, 0, '0, 0, 1);
        cyc(0, 0, '0, 0, 0);
        cyc(1, 0, '0, 0, 0);
        cyc(0, 1, '1, 0, 0);
        for (int i = 1; i < BC; i++) cyc(0, 1, '0, 0, 0);
        cyc(0, 0, '0, 0, 0);
        chk("lsb_first_all_nodes", bus.array_out, {N{one}});
        cyc(0, 0, '0, 1, 0);
        cyc(1, 0, '0, 0, 0);
        for (int i = 0; i < BC; i++) begin
            cyc(0, 1, (N'($urandom) & ~N'(1)) | pat[i], 0, 0);
            if (i < BC - 1) begin
                cyc(0, 0, '0, 0, 0);
                cyc(0, 0, '0, 0, 0);
            end
        end
        cyc(0, 0, '0, 0, 0);
        chk("node1_gapped", W'(bus.array_out[BC-1:0]), W'(6'b001101));
        for (int i = 0; i < 10; i++) cyc(0, i == 4, N'($urandom), 0, 0);
        cyc(0, 0, '0, 1, 0);
        cyc(0, 0, '0, 0, 1);
        cyc(1, 1, N'($urandom), 0, 0);
        bits(2, 0);
        cyc(1, 0, '0, 0, 0);
        bits(BC, 1);
        cyc(0, 0, '0, 1, 0);
        cyc(1, 0, '0, 0, 0);
        bits(4, 0);
        cyc(0, 0, '0, 0, 1);
        cyc(1, 0, '0, 0, 0);
        bits(BC, 0);
        cyc(0, 0, '0, 0, 0);
        cyc(1, 0, '0, 1, 0);
        bits(BC, 0);
        cyc(1, 1, N'($urandom), 1, 0);
        bits(BC - 1, 0);
        cyc(1, 0, '0, 0, 0);
        cyc(0, 0, '0, 1, 0);
        for (int i = 0; i < 4000; i++)
            cyc($urandom_range(0, 11) == 0, $urandom_range(0, 2) != 0, N'($urandom),
                $urandom_range(0, 3) == 0, $urandom_range(0, 199) == 0);
        for (int i = 0; i < 4; i++) cyc(0, 0, '0, 1, 0);
        chk("queue_empty", W'(exp_q.size()), '0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/node_bit_collector.md
NODE_BIT_COLLECTOR -- requirements
Module: node_bit_collector

Interface
REQ-001 Parameter BIT_CHIP, default 6: bits per node sample word.
REQ-002 Parameter NODE, default 16: number of nodes sampled in parallel.
REQ-003 clk  input  1  single clock; all logic on rising edge.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 start  input  1  one-cycle pulse; begins collection of one word per node.
REQ-006 bit_valid  input  1  bit_in carries one valid bit per node this cycle.
REQ-007 bit_in  input  NODE  serial bit of node a on bit_in[a-1].
REQ-008 array_ready  input  1  downstream reroute/consumer accepts array_out.
REQ-009 array_out  output  BIT_CHIP*NODE  packed collected words; node a occupies [a*BIT_CHIP-1:(a-1)*BIT_CHIP].
REQ-010 array_valid  output  1  array_out holds a complete word set.
REQ-011 busy  output  1  high in SHIFT or HOLD.
REQ-012 overrun  output  1  sticky error: bit_valid seen outside SHIFT.

Function
REQ-013 The block SHALL implement FSM states IDLE, SHIFT, HOLD.
REQ-014 IDLE -> SHIFT on start; bit counter cleared to 0, array_out register cleared to 0.
REQ-015 In SHIFT, each cycle with bit_valid SHALL write bit_in[a-1] to array_out[(a-1)*BIT_CHIP+cnt] for all a, then increment cnt.
REQ-016 First-received bit therefore lands at the lowest index of each field (arrival order LSB-first; downstream bit reversal restores MSB-first).
REQ-017 Cycles in SHIFT without bit_valid SHALL leave array_out and cnt unchanged.
REQ-018 The bit accepted at cnt = BIT_CHIP-1 SHALL move FSM to HOLD; array_valid asserts the following cycle (one-cycle latency from last bit).
REQ-019 cnt width SHALL be ceil(log2(BIT_CHIP)) bits minimum 1; cnt never exceeds BIT_CHIP-1.
REQ-020 In HOLD, array_out and array_valid SHALL be stable until array_valid & array_ready; then FSM -> IDLE, array_valid deasserts next cycle.
REQ-021 start in HOLD with array_ready same cycle SHALL complete the handshake and enter SHIFT directly (back-to-back); start in HOLD without array_ready SHALL be ignored.
REQ-022 start in SHIFT SHALL abort: cnt and array_out cleared, remain in SHIFT; a bit_valid in the same cycle SHALL be taken as bit 0 of the new word.
REQ-023 start and bit_valid same cycle in IDLE SHALL enter SHIFT and capture that bit as bit 0.
REQ-024 bit_valid in HOLD (or IDLE without start) SHALL set overrun; bit discarded; overrun cleared only by rst.
REQ-025 busy SHALL equal (state != IDLE).
REQ-026 array_out SHALL be driven directly from registers (no combinational path from inputs).

Reset
REQ-027 rst SHALL force state IDLE, cnt 0, array_out 0, array_valid 0, busy 0, overrun 0 on the next rising edge.
REQ-028 rst mid-SHIFT or mid-HOLD SHALL discard the partial/pending word with no array_valid pulse.
REQ-029 rst SHALL take priority over start, bit_valid, and array_ready.

Structure
REQ-030 FSM state enumeration and the BIT_CHIP/NODE defaults SHALL live in the shared LandscapeSampling package, reused by the reroute stage.
REQ-031 The block SHALL be a single module; no sub-module; per-node write SHALL be a generate loop over NODE.
REQ-032 array_out SHALL connect without adaptation to the array_in port of the downstream bit-reversal stage.

Verification
REQ-033 Defaults; start, then 6 consecutive bit_valid with bit_in = 16'hFFFF,0,0,0,0,0 -> array_valid after cycle 7; every field = 6'b000001.
REQ-034 Node 1 bits 1,0,1,1,0,0 with gaps (bit_valid low 2 cycles between bits) -> field 1 = 6'b001101, array_valid only after 6th bit.
REQ-035 array_ready held low 10 cycles in HOLD with bit_valid pulse -> array_out unchanged, overrun=1, array_valid stays 1.
REQ-036 start issued after 3 bits -> word restarts; 6 further bits produce only new data, old bits absent.
REQ-037 rst asserted after 4 bits -> next cycle all outputs 0, no array_valid; fresh start collects correctly.
REQ-038 HOLD with array_ready=1 and start=1 same cycle -> array_valid drops, state SHIFT, next word collected with zero idle cycles.
